// File: rtl/neural_compressor_pkg.sv
// Shared types and defaults for the neural compressor datapath.
// Holds the sample width and the spike snippet packetizer's state type and defaults.
package neural_compressor_pkg;

  localparam int DATA_WIDTH = 16;

  localparam int SNIP_PRE  = 8;
  localparam int SNIP_POST = 16;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    EMIT
  } snippet_state_t;

endpackage

// File: rtl/snippet_ring_buffer.sv
// Circular sample store for the snippet packetizer. It has a registered write
// port with a self-wrapping write pointer and an asynchronous read port.
module snippet_ring_buffer #(
  parameter int DEPTH      = 25,
  parameter int DATA_WIDTH = 16,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [PTR_W-1:0]      wr_ptr
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage is reset so that ring contents are defined after reset.
  // Because of this the array is built from flops and cannot map onto a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spike_snippet_packetizer.sv
// Captures PRE/spike/POST sample windows around flagged spikes and emits each
// window as a framed packet: a timestamp header followed by the samples, oldest first.
module spike_snippet_packetizer
  import neural_compressor_pkg::*;
#(
  parameter int PRE_SAMPLES  = SNIP_PRE,
  parameter int POST_SAMPLES = SNIP_POST,
  parameter int TS_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  spike_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] pkt_data,
  output logic                  pkt_sop,
  output logic                  pkt_eop,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic [15:0]           event_count,
  output logic [15:0]           drop_count
);

  localparam int DEPTH   = PRE_SAMPLES + 1 + POST_SAMPLES;
  localparam int PKT_LEN = DEPTH + 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int SUM_W   = PTR_W + 1;
  localparam int PRE_W   = $clog2(PRE_SAMPLES + 1);
  localparam int POST_W  = $clog2(POST_SAMPLES + 1);
  localparam int IDX_W   = $clog2(PKT_LEN);

  snippet_state_t        state;
  logic [TS_WIDTH-1:0]   ts;
  logic [DATA_WIDTH-1:0] hdr_ts;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      start_ptr;
  logic [SUM_W-1:0]      start_sum;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [POST_W-1:0]     post_cnt;
  logic [IDX_W-1:0]      emit_idx;
  logic [PRE_W-1:0]      pre_cnt;
  logic                  primed;
  logic                  accept;
  logic                  handshake;

  assign accept    = valid_in && ready_out;
  assign handshake = pkt_valid && pkt_ready;

  // The oldest snippet sample sits PRE_SAMPLES slots behind the spike's write slot.
  assign start_sum = {1'b0, wr_ptr} + SUM_W'(DEPTH - PRE_SAMPLES);
  assign start_ptr = (start_sum >= SUM_W'(DEPTH)) ? PTR_W'(start_sum - SUM_W'(DEPTH))
                                                  : PTR_W'(start_sum);

  snippet_ring_buffer #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data),
    .wr_ptr  (wr_ptr)
  );

  // NOTE: every register here is updated with a non-blocking assignment. Each branch
  // therefore reads the values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ready_out   <= 1'b0;
      ts          <= '0;
      hdr_ts      <= '0;
      rd_ptr      <= '0;
      post_cnt    <= '0;
      emit_idx    <= '0;
      pre_cnt     <= '0;
      primed      <= 1'b0;
      pkt_data    <= '0;
      pkt_sop     <= 1'b0;
      pkt_eop     <= 1'b0;
      pkt_valid   <= 1'b0;
      event_count <= '0;
      drop_count  <= '0;
    end else begin
      if (accept) ts <= ts + 1'b1;

      if (accept && !primed) begin
        pre_cnt <= pre_cnt + 1'b1;
        if (pre_cnt == PRE_W'(PRE_SAMPLES - 1)) primed <= 1'b1;
      end

      case (state)
        IDLE: begin
          ready_out <= 1'b1;
          if (accept && spike_in) begin
            if (primed) begin
              // rd_ptr holds the snippet start until emission walks it forward.
              rd_ptr   <= start_ptr;
              hdr_ts   <= ts[DATA_WIDTH-1:0];
              post_cnt <= POST_W'(POST_SAMPLES);
              state    <= CAPTURE;
            end else if (drop_count != 16'hFFFF) begin
              drop_count <= drop_count + 1'b1;
            end
          end
        end

        CAPTURE: begin
          if (accept) begin
            if (spike_in && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == POST_W'(1)) begin
              state     <= EMIT;
              ready_out <= 1'b0;
              pkt_valid <= 1'b1;
              pkt_sop   <= 1'b1;
              pkt_eop   <= 1'b0;
              pkt_data  <= hdr_ts;
              emit_idx  <= '0;
            end
          end
        end

        EMIT: begin
          if (handshake) begin
            if (pkt_eop) begin
              pkt_valid <= 1'b0;
              pkt_eop   <= 1'b0;
              state     <= IDLE;
              ready_out <= 1'b1;
              if (event_count != 16'hFFFF) event_count <= event_count + 1'b1;
            end else begin
              pkt_data <= rd_data;
              pkt_sop  <= 1'b0;
              pkt_eop  <= (emit_idx == IDX_W'(PKT_LEN - 2));
              emit_idx <= emit_idx + 1'b1;
              rd_ptr   <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
